// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the host command link.
//   frame_state_t : position within a 3-byte command frame
//   DATA_BITS / FRAME_BITS : 8N1 geometry
//   command encodings exchanged with the remote
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    WAIT_CMD = 2'd0,
    WAIT_HI  = 2'd1,
    WAIT_LO  = 2'd2
  } frame_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;  // start + 8 data + stop

  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] CAL       = 8'h06;
  localparam logic [7:0] EMER_LAND = 8'h07;
  localparam logic [7:0] MTRS_OFF  = 8'h08;
  localparam logic [7:0] POS_ACK   = 8'hA5;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver.
//   clk, rst_n  : system clock, async active-low reset
//   rx          : raw serial input, idle high, asynchronous to clk
//   rx_byte     : last good byte (updated together with rx_good)
//   rx_good     : 1-cycle strobe, byte with valid stop bit received
//   rx_frm_err  : 1-cycle strobe, stop bit sampled low (byte dropped)
module uart_byte_rx
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_good,
  output logic       rx_frm_err
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BAUD_DIV - 1);
  localparam logic [2:0]    LAST_IDX  = 3'(DATA_BITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic          rx_s1, rx_s2, rx_prev;
  logic [1:0]    st;
  logic [BW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shft;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      st         <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shft       <= '0;
      rx_byte    <= '0;
      rx_good    <= 1'b0;
      rx_frm_err <= 1'b0;
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      rx_good    <= 1'b0;
      rx_frm_err <= 1'b0;
      case (st)
        // only a true 1->0 edge starts a byte; a line held low stays idle
        S_IDLE: if (rx_prev && !rx_s2) begin
          st  <= S_START;
          cnt <= '0;
        end
        // mid-start re-check rejects glitches and aligns later samples to bit centres
        S_START: if (cnt == HALF_LAST) begin
          cnt <= '0;
          if (rx_s2) st <= S_IDLE;
          else begin
            st      <= S_DATA;
            bit_idx <= '0;
          end
        end else cnt <= cnt + 1'b1;
        S_DATA: if (cnt == BIT_LAST) begin
          cnt     <= '0;
          shft    <= {rx_s2, shft[7:1]};  // LSB first
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == LAST_IDX) st <= S_STOP;
        end else cnt <= cnt + 1'b1;
        // returning to idle at mid-stop leaves half a bit to catch the next start edge
        S_STOP: if (cnt == BIT_LAST) begin
          cnt <= '0;
          st  <= S_IDLE;
          if (rx_s2) begin
            rx_good <= 1'b1;
            rx_byte <= shft;
          end else rx_frm_err <= 1'b1;
        end else cnt <= cnt + 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Host command link endpoint: assembles 3-byte commands (cmd, data_hi,
// data_lo) from the RX line and serializes 1-byte responses on TX.
//   clk, rst_n   : system clock, async active-low reset
//   RX / TX      : serial in / out, idle high, 8N1, BAUD_DIV clocks per bit
//   cmd, data    : last complete frame, held until the next one completes
//   cmd_rdy      : frame available; cleared by clr_cmd_rdy or by the first
//                  byte of a new frame (a completing frame wins over a clear)
//   resp         : response byte, latched on send_resp when tx_busy=0
//   send_resp    : 1-cycle start strobe, ignored while tx_busy=1
//   resp_sent    : 1-cycle pulse at the end of the stop bit
//   tx_busy      : transmitter active
// Optional build macro UART_CMD_FRAME_TIMEOUT_EN: a partial frame idle for
// TIMEOUT_CYC cycles is discarded. Without it a partial frame waits forever.
module uart_cmd_wrapper
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV    = 2604,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy
);

  if (BAUD_DIV < 8 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("uart_cmd_wrapper: BAUD_DIV must be >= 8 and TIMEOUT_CYC >= 1");
  end

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BIT_LAST = BW'(BAUD_DIV - 1);
  localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS - 1);

  // ---------------- receive + frame assembly ----------------
  logic [7:0]   rx_byte;
  logic         rx_good, rx_frm_err;
  frame_state_t fstate;
  logic [7:0]   cmd_buf, hi_buf;
  logic         frame_done, first_ok, frame_to;

  uart_byte_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (RX),
    .rx_byte   (rx_byte),
    .rx_good   (rx_good),
    .rx_frm_err(rx_frm_err)
  );

  assign frame_done = rx_good && (fstate == WAIT_LO);
  assign first_ok   = rx_good && (fstate == WAIT_CMD);

`ifdef UART_CMD_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;

  // counts idle cycles since the last good byte of a partial frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt <= '0;
    else if (rx_good || fstate == WAIT_CMD || frame_to) to_cnt <= '0;
    else to_cnt <= to_cnt + 1'b1;
  end

  assign frame_to = (fstate != WAIT_CMD) && !rx_good && (to_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign frame_to = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fstate  <= WAIT_CMD;
      cmd_buf <= '0;
      hi_buf  <= '0;
      cmd     <= '0;
      data    <= '0;
      cmd_rdy <= 1'b0;
    end else begin
      // a bad byte or stale partial frame restarts assembly; outputs untouched
      if (rx_frm_err || frame_to) fstate <= WAIT_CMD;
      else if (rx_good) begin
        case (fstate)
          WAIT_CMD: begin
            cmd_buf <= rx_byte;
            fstate  <= WAIT_HI;
          end
          WAIT_HI: begin
            hi_buf <= rx_byte;
            fstate <= WAIT_LO;
          end
          WAIT_LO: begin
            cmd    <= cmd_buf;
            data   <= {hi_buf, rx_byte};
            fstate <= WAIT_CMD;
          end
          default: fstate <= WAIT_CMD;
        endcase
      end
      if (frame_done) cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy || first_ok) cmd_rdy <= 1'b0;
    end
  end

  // ---------------- transmit ----------------
  // TX is bit 0 of a shift register of the remaining frame; idle = all ones,
  // so the pin stays high between bytes and straight after reset.
  logic [FRAME_BITS-1:0] tx_frame;
  logic [BW-1:0]         tx_cnt;
  logic [3:0]            tx_bit;

  assign TX = tx_frame[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_frame  <= '1;
      tx_busy   <= 1'b0;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      resp_sent <= 1'b0;
    end else begin
      resp_sent <= 1'b0;
      if (!tx_busy) begin
        if (send_resp) begin
          tx_frame <= {1'b1, resp, 1'b0};
          tx_busy  <= 1'b1;
          tx_cnt   <= '0;
          tx_bit   <= '0;
        end
      end else if (tx_cnt == BIT_LAST) begin
        tx_cnt <= '0;
        if (tx_bit == LAST_BIT) begin
          tx_busy   <= 1'b0;
          resp_sent <= 1'b1;
          tx_frame  <= '1;
        end else begin
          tx_bit   <= tx_bit + 1'b1;
          tx_frame <= {1'b1, tx_frame[FRAME_BITS-1:1]};
        end
      end else tx_cnt <= tx_cnt + 1'b1;
    end
  end

endmodule
